// File: rtl/load_writeback_unit.sv
// RV32I load writeback stage: memory req/gnt/rvalid handshake, byte/half extraction and ALU merge
// onto the single register-file write port. Optional macro LOAD_MISALIGN_TRAP_EN traps misaligned loads.
module load_writeback_unit #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ld_valid,
   output logic                  ld_ready,
   input  logic [ADDR_WIDTH-1:0] ld_addr,
   input  logic [2:0]            ld_funct3,
   input  logic [4:0]            ld_rd,
   input  logic                  alu_we,
   input  logic [4:0]            alu_rd,
   input  logic [WIDTH-1:0]      alu_data,
   output logic                  alu_stall,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_gnt,
   input  logic                  mem_rvalid,
   input  logic [WIDTH-1:0]      mem_rdata,
   output logic                  rf_write_enable,
   output logic [4:0]            rf_dest,
   output logic [WIDTH-1:0]      rf_data,
   output logic                  busy,
   output logic                  bus_err,
   output logic                  misalign_err
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_WB} state_t;

   localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

   state_t                state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [2:0]            funct3_q, funct3_d;
   logic [4:0]            rd_q, rd_d;
   logic [WIDTH-1:0]      data_q, data_d;
   logic                  bus_err_q, bus_err_d;
   logic                  misalign_d;
   logic                  funct3_legal;
   logic                  misaligned;
   logic                  cnt_at_limit;
   logic [7:0]            byte_sel;
   logic [15:0]           half_sel;
   logic [WIDTH-1:0]      ext_data;

   assign funct3_legal = (ld_funct3 == 3'b000) || (ld_funct3 == 3'b001) || (ld_funct3 == 3'b010) ||
                         (ld_funct3 == 3'b100) || (ld_funct3 == 3'b101);

`ifdef LOAD_MISALIGN_TRAP_EN
   logic misalign_q;
   assign misaligned = ((ld_funct3 == 3'b001 || ld_funct3 == 3'b101) && ld_addr[0]) ||
                       ((ld_funct3 == 3'b010) && (ld_addr[1:0] != 2'b00));
   assign misalign_err = misalign_q;
`else
   assign misaligned   = 1'b0;
   assign misalign_err = 1'b0;
`endif

   // Counter saturates at the limit so a grant on the last allowed cycle still gets one WAIT cycle.
   assign cnt_at_limit = (cnt_q == TIMEOUT_CNT);

   always_comb begin
      byte_sel = mem_rdata[7:0];
      case (addr_q[1:0])
         2'b01:   byte_sel = mem_rdata[15:8];
         2'b10:   byte_sel = mem_rdata[23:16];
         2'b11:   byte_sel = mem_rdata[31:24];
         default: byte_sel = mem_rdata[7:0];
      endcase
      half_sel = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (funct3_q)
         3'b000:  ext_data = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
         3'b100:  ext_data = {{(WIDTH-8){1'b0}}, byte_sel};
         3'b001:  ext_data = {{(WIDTH-16){half_sel[15]}}, half_sel};
         3'b101:  ext_data = {{(WIDTH-16){1'b0}}, half_sel};
         default: ext_data = mem_rdata;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      funct3_d   = funct3_q;
      rd_d       = rd_q;
      data_d     = data_q;
      bus_err_d  = 1'b0;
      misalign_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ld_valid) begin
               addr_d   = ld_addr;
               funct3_d = ld_funct3;
               rd_d     = ld_rd;
               if (!funct3_legal) begin
                  bus_err_d = 1'b1;
               end else if (misaligned) begin
                  misalign_d = 1'b1;
               end else begin
                  state_d = S_REQ;
                  cnt_d   = 8'd0;
               end
            end
         end
         S_REQ: begin
            if (!cnt_at_limit) cnt_d = cnt_q + 8'd1;
            if (mem_gnt) begin
               state_d = S_WAIT;
            end else if (cnt_at_limit) begin
               bus_err_d = 1'b1;
               state_d   = S_IDLE;
            end
         end
         S_WAIT: begin
            if (!cnt_at_limit) cnt_d = cnt_q + 8'd1;
            if (mem_rvalid) begin
               data_d  = ext_data;
               state_d = S_WB;
            end else if (cnt_at_limit) begin
               bus_err_d = 1'b1;
               state_d   = S_IDLE;
            end
         end
         S_WB: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= 8'd0;
         addr_q    <= '0;
         funct3_q  <= 3'b000;
         rd_q      <= 5'd0;
         data_q    <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         funct3_q  <= funct3_d;
         rd_q      <= rd_d;
         data_q    <= data_d;
         bus_err_q <= bus_err_d;
      end
   end

`ifdef LOAD_MISALIGN_TRAP_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) misalign_q <= 1'b0;
      else        misalign_q <= misalign_d;
   end
`else
   logic unused_misalign;
   assign unused_misalign = misalign_d;
`endif

   assign ld_ready = (state_q == S_IDLE);
   assign busy     = (state_q != S_IDLE);
   assign mem_req  = (state_q == S_REQ);
   assign mem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
   assign bus_err  = bus_err_q;

   // Load writeback owns the port in WB; register x0 is never written.
   always_comb begin
      if (state_q == S_WB) begin
         rf_write_enable = (rd_q != 5'd0);
         rf_dest         = rd_q;
         rf_data         = data_q;
         alu_stall       = alu_we;
      end else begin
         rf_write_enable = alu_we && (alu_rd != 5'd0);
         rf_dest         = alu_rd;
         rf_data         = alu_data;
         alu_stall       = 1'b0;
      end
   end

endmodule

// File: tb/tb_load_writeback_unit.sv
// Randomized self-checking bench for load_writeback_unit against a cycle-count reference model.
module tb_load_writeback_unit;
   localparam int TO = 4;

   logic        clk;
   logic        reset;
   logic        ld_valid, ld_ready;
   logic [31:0] ld_addr;
   logic [2:0]  ld_funct3;
   logic [4:0]  ld_rd;
   logic        alu_we, alu_stall;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        mem_req, mem_gnt, mem_rvalid;
   logic [31:0] mem_addr, mem_rdata;
   logic        rf_write_enable;
   logic [4:0]  rf_dest;
   logic [31:0] rf_data;
   logic        busy, bus_err, misalign_err;

   int checks = 0;
   int fails  = 0;

   load_writeback_unit #(.WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_funct3(ld_funct3), .ld_rd(ld_rd),
      .alu_we(alu_we), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .rf_write_enable(rf_write_enable), .rf_dest(rf_dest), .rf_data(rf_data),
      .busy(busy), .bus_err(bus_err), .misalign_err(misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Architectural value of a load: shift the addressed lane down, mask, then extend.
   function automatic logic [31:0] ref_extract(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] w);
      logic [31:0] v;
      int unsigned sh;
      case (f3)
         3'b000, 3'b100: begin
            sh = 8 * (a % 4);
            v  = (w >> sh) & 32'hFF;
            if (f3 == 3'b000 && v >= 32'd128) v = v + 32'hFFFFFF00;
         end
         3'b001, 3'b101: begin
            sh = 16 * ((a / 2) % 2);
            v  = (w >> sh) & 32'hFFFF;
            if (f3 == 3'b001 && v >= 32'd32768) v = v + 32'hFFFF0000;
         end
         default: v = w;
      endcase
      return v;
   endfunction

   // One load transaction: grant dg cycles after REQ entry, rvalid dr cycles after WAIT entry.
   task automatic run_load(input string tag, input logic [31:0] a, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] w, input int dg, input int dr);
      bit illegal, mis, tmo;
      int g_cyc, r_cyc, tc, wb_cyc, err_cyc, last_busy, n, wait_lim;
      logic [31:0] exp_data;
      logic [6:0]  ctl_exp, ctl_got;
      logic [36:0] rf_exp;
      bit in_wb;
      illegal = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      mis = 1'b0;
`ifdef LOAD_MISALIGN_TRAP_EN
      mis = !illegal && (((f3 == 3'b001 || f3 == 3'b101) && a[0]) || (f3 == 3'b010 && a[1:0] != 2'b00));
`endif
      g_cyc = 1 + dg;
      r_cyc = g_cyc + 1 + dr;
      tmo = 1'b0; tc = 0; wb_cyc = -1; err_cyc = -1; last_busy = 0;
      wait_lim = (g_cyc + 1 > TO + 1) ? g_cyc + 1 : TO + 1;
      if (illegal || mis) begin
         err_cyc = 1; n = 3;
      end else begin
         if (g_cyc > TO + 1) begin
            tmo = 1'b1; tc = TO + 1;
         end else if (r_cyc > wait_lim) begin
            tmo = 1'b1; tc = wait_lim;
         end
         if (tmo) begin
            last_busy = tc; err_cyc = tc + 1; n = tc + 2;
         end else begin
            wb_cyc = r_cyc + 1; last_busy = wb_cyc; n = wb_cyc + 2;
         end
      end
      exp_data = ref_extract(a, f3, w);
      for (int k = 0; k < n; k++) begin
         ld_valid = (k == 0);
         if (k == 0) begin
            ld_addr = a; ld_funct3 = f3; ld_rd = rd;
         end else begin
            ld_addr = $urandom; ld_funct3 = 3'($urandom_range(0, 7)); ld_rd = 5'($urandom_range(0, 31));
         end
         mem_gnt    = (k == g_cyc);
         mem_rvalid = (k == r_cyc) || (k <= g_cyc && $urandom_range(0, 1) == 1);
         mem_rdata  = (k == r_cyc) ? w : $urandom;
         alu_we     = ($urandom_range(0, 1) == 1);
         alu_rd     = 5'($urandom_range(0, 31));
         alu_data   = $urandom;
         @(negedge clk);
         in_wb = (k == wb_cyc);
         ctl_exp[6] = !(k >= 1 && k <= last_busy);
         ctl_exp[5] = (k >= 1 && k <= last_busy);
         ctl_exp[4] = !illegal && !mis && k >= 1 && k <= g_cyc && k <= last_busy;
         ctl_exp[3] = (k == err_cyc) && (illegal || tmo);
         ctl_exp[2] = (k == err_cyc) && mis;
         ctl_exp[1] = in_wb && alu_we;
         ctl_exp[0] = in_wb ? (rd != 5'd0) : (alu_we && alu_rd != 5'd0);
         rf_exp     = in_wb ? {rd, exp_data} : {alu_rd, alu_data};
         ctl_got = {ld_ready, busy, mem_req, bus_err, misalign_err, alu_stall, rf_write_enable};
         checks++;
         if (ctl_got !== ctl_exp) begin
            fails++;
            $display("FAIL %s ctl k=%0d got %b want %b (ready,busy,req,buserr,mis,stall,we)", tag, k, ctl_got, ctl_exp);
         end
         checks++;
         if ({rf_dest, rf_data} !== rf_exp) begin
            fails++;
            $display("FAIL %s rf k=%0d got rd=%0d data=%h want rd=%0d data=%h", tag, k, rf_dest, rf_data,
                     rf_exp[36:32], rf_exp[31:0]);
         end
         if (ctl_exp[4]) begin
            checks++;
            if (mem_addr !== {a[31:2], 2'b00}) begin
               fails++;
               $display("FAIL %s mem_addr k=%0d got %h want %h", tag, k, mem_addr, {a[31:2], 2'b00});
            end
         end
         next_cycle();
      end
      ld_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; alu_we = 1'b0;
      $display("load %s addr=%h f3=%0d rd=%0d dg=%0d dr=%0d", tag, a, f3, rd, dg, dr);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      ld_valid = 1'b0; ld_addr = '0; ld_funct3 = '0; ld_rd = '0;
      alu_we = 1'b1; alu_rd = 5'd9; alu_data = 32'h000000A5;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      #3;
      checks++;
      if ({ld_ready, busy, mem_req, bus_err, misalign_err, alu_stall} !== 6'b100000) begin
         fails++;
         $display("FAIL reset_ctl got %b want 100000", {ld_ready, busy, mem_req, bus_err, misalign_err, alu_stall});
      end
      checks++;
      if ({rf_write_enable, rf_dest, rf_data} !== {1'b1, 5'd9, 32'h000000A5}) begin
         fails++;
         $display("FAIL reset_rf got we=%b rd=%0d data=%h want we=1 rd=9 data=000000a5", rf_write_enable, rf_dest, rf_data);
      end
      next_cycle();
      next_cycle();
      reset = 1'b1;
      alu_we = 1'b0;
      next_cycle();
      $display("reset applied and released");
   endtask

   task automatic test_alu_collision();
      ld_valid = 1'b1; ld_addr = 32'h40; ld_funct3 = 3'b010; ld_rd = 5'd3;
      next_cycle();
      ld_valid = 1'b0; mem_gnt = 1'b1;
      next_cycle();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA1B2C3D4;
      next_cycle();
      mem_rvalid = 1'b0; alu_we = 1'b1; alu_rd = 5'd7; alu_data = 32'h1234;
      @(negedge clk);
      checks++;
      if ({alu_stall, rf_write_enable, rf_dest, rf_data} !== {1'b1, 1'b1, 5'd3, 32'hA1B2C3D4}) begin
         fails++;
         $display("FAIL collide_wb got stall=%b we=%b rd=%0d data=%h want stall=1 we=1 rd=3 data=a1b2c3d4",
                  alu_stall, rf_write_enable, rf_dest, rf_data);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if ({alu_stall, rf_write_enable, rf_dest, rf_data} !== {1'b0, 1'b1, 5'd7, 32'h1234}) begin
         fails++;
         $display("FAIL collide_alu got stall=%b we=%b rd=%0d data=%h want stall=0 we=1 rd=7 data=00001234",
                  alu_stall, rf_write_enable, rf_dest, rf_data);
      end
      next_cycle();
      alu_we = 1'b0;
      $display("alu collision load x3 then alu x7");
   endtask

   task automatic test_stray_rvalid();
      mem_rvalid = 1'b1; mem_rdata = 32'h55555555; alu_we = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, rf_write_enable, bus_err} !== 3'b000) begin
         fails++;
         $display("FAIL stray_rvalid got busy=%b we=%b buserr=%b want 000", busy, rf_write_enable, bus_err);
      end
      next_cycle();
      mem_rvalid = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, rf_write_enable} !== 2'b00) begin
         fails++;
         $display("FAIL stray_after got busy=%b we=%b want 00", busy, rf_write_enable);
      end
      next_cycle();
      $display("stray rvalid in idle");
   endtask

   task automatic test_reset_inflight();
      alu_we = 1'b0;
      ld_valid = 1'b1; ld_addr = 32'h300; ld_funct3 = 3'b010; ld_rd = 5'd8;
      next_cycle();
      ld_valid = 1'b0; mem_gnt = 1'b1;
      next_cycle();
      mem_gnt = 1'b0;
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({ld_ready, busy, mem_req, rf_write_enable} !== 4'b1000) begin
         fails++;
         $display("FAIL reset_wait got ready=%b busy=%b req=%b we=%b want 1000", ld_ready, busy, mem_req, rf_write_enable);
      end
      @(posedge clk);
      #1 reset = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
      next_cycle();
      mem_rvalid = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, rf_write_enable} !== 2'b00) begin
         fails++;
         $display("FAIL reset_late_rvalid got busy=%b we=%b want 00", busy, rf_write_enable);
      end
      next_cycle();
      $display("reset during WAIT");
      run_load("rd0", 32'h304, 3'b010, 5'd0, 32'h11111111, 0, 0);
   endtask

   task automatic test_random(input int count);
      logic [2:0] f3;
      for (int i = 0; i < count; i++) begin
         f3 = 3'($urandom_range(0, 7));
         run_load("rand", $urandom, f3, 5'($urandom_range(0, 31)), $urandom,
                  int'($urandom_range(0, 5)), int'($urandom_range(0, 4)));
      end
   endtask

   initial begin
      test_reset();
      run_load("lw_basic", 32'h100, 3'b010, 5'd5, 32'hDEADBEEF, 0, 0);
      run_load("back2back", 32'h104, 3'b010, 5'd6, 32'h0BADF00D, 0, 0);
      run_load("lb_sign", 32'h103, 3'b000, 5'd10, 32'h80112233, 0, 0);
      run_load("lbu", 32'h103, 3'b100, 5'd11, 32'h80112233, 1, 2);
      run_load("lhu", 32'h102, 3'b101, 5'd12, 32'h80112233, 2, 1);
      run_load("lh_sign", 32'h100, 3'b001, 5'd13, 32'h1234F00F, 0, 1);
      test_alu_collision();
      run_load("timeout_req", 32'h200, 3'b010, 5'd6, 32'h22222222, 100, 0);
      test_stray_rvalid();
      run_load("timeout_wait", 32'h204, 3'b010, 5'd6, 32'h33333333, 0, 10);
      run_load("edge_gnt", 32'h208, 3'b010, 5'd14, 32'h44444444, TO, 0);
      run_load("illegal_f3", 32'h100, 3'b011, 5'd2, 32'h66666666, 0, 0);
      test_reset_inflight();
      run_load("misalign_lw", 32'h102, 3'b010, 5'd4, 32'hCAFEF00D, 0, 0);
      run_load("misalign_lh", 32'h101, 3'b001, 5'd15, 32'hCAFEF00D, 0, 0);
      test_random(60);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
